// File: rtl/dma_priority_resolver_pkg.sv
// -----------------------------------------------------------------------------
// dma_priority_resolver_pkg
//   Shared types for the DMA request/priority stage: channel select values,
//   channel index type, channel count and the resolver state encoding.
//   The resolver state enum is one-hot. The index enum names the bit position
//   of each state inside that one-hot vector.
// -----------------------------------------------------------------------------
package dma_priority_resolver_pkg;

    localparam int NUM_CH = 4;

    typedef logic [1:0] ch_idx_t;

    typedef enum logic [1:0] {
        CH_SEL_0 = 2'd0,
        CH_SEL_1 = 2'd1,
        CH_SEL_2 = 2'd2,
        CH_SEL_3 = 2'd3
    } CHANNEL_SELECT_e;

    typedef enum int unsigned {
        IDX_IDLE     = 0,
        IDX_HOLD_REQ = 1,
        IDX_SERVICE  = 2,
        IDX_RELEASE  = 3
    } res_state_idx_e;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'b0001 << IDX_IDLE,
        ST_HOLD_REQ = 4'b0001 << IDX_HOLD_REQ,
        ST_SERVICE  = 4'b0001 << IDX_SERVICE,
        ST_RELEASE  = 4'b0001 << IDX_RELEASE
    } res_state_e;

    // One-hot acknowledge pattern for a channel index.
    function automatic logic [3:0] ch_onehot(input ch_idx_t ch);
        return 4'b0001 << ch;
    endfunction

endpackage

// File: rtl/dma_priority_encoder.sv
// -----------------------------------------------------------------------------
// dma_priority_encoder
//   Combinational rotating-priority picker. The scan starts at pri_ptr and
//   moves upward modulo 4. The first set request bit wins. When pri_ptr is 0
//   this is plain fixed priority with channel 0 highest.
// Ports
//   req      in  4  qualified requests
//   pri_ptr  in  2  channel that currently has highest priority
//   winner   out 2  selected channel (0 when no request is set)
//   any      out 1  at least one request is set
// -----------------------------------------------------------------------------
module dma_priority_encoder
    import dma_priority_resolver_pkg::*;
(
    input  logic [3:0] req,
    input  logic [1:0] pri_ptr,
    output logic [1:0] winner,
    output logic       any
);

    logic [1:0] w_idx;

    // The scan runs from the lowest priority up to the highest. The last hit
    // therefore belongs to the highest-priority requester.
    always_comb begin
        winner = 2'd0;
        any    = 1'b0;
        w_idx  = 2'd0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            w_idx = pri_ptr + 2'(k);
            if (req[w_idx]) begin
                winner = w_idx;
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dma_priority_resolver.sv
// -----------------------------------------------------------------------------
// dma_priority_resolver
//   Request/priority stage of an 8237A-style DMA controller.
//   - It qualifies the DREQ lines and raises HRQ to the CPU.
//   - On HLDA it picks one channel using fixed or rotating priority.
//   - It drives DACK and passes ch_sel/grant_valid to the timing FSM.
//   - It holds the grant until the timing FSM pulses svc_done.
//
//   State | meaning
//   ------+-----------------------------------------------------------------
//   IDLE     | no bus request; waiting for any qualified request
//   HOLD_REQ | hrq high; waiting for hlda, then arbitrate
//   SERVICE  | grant frozen, dack active; waiting for svc_done or hlda drop
//   RELEASE  | one cycle with hrq/dack/grant off before returning to IDLE
//
// Configuration macro
//   DMA_DREQ_SYNC_EN : when defined, dreq passes through a SYNC_STAGES-deep
//                      synchroniser before the polarity XOR. sw_req is never
//                      synchronised.
//
// Ports
//   clk, reset    clock and asynchronous active-high reset
//   dreq[3:0]     hardware requests, polarity selected by dreq_sense
//   dreq_sense    0 = DREQ active high, 1 = active low
//   dack_sense    1 = DACK active high, 0 = active low
//   rot_pri       1 = rotating priority, 0 = fixed priority (ch0 highest)
//   ctrl_disable  blocks all requests
//   mask[3:0]     1 = hardware DREQ ignored
//   sw_req[3:0]   software requests (not maskable)
//   hlda          hold acknowledge from CPU
//   svc_done      1-cycle end-of-service pulse from the timing FSM
//   hrq           registered hold request
//   dack[3:0]     DMA acknowledge, polarity set by dack_sense
//   ch_sel[1:0]   granted channel, valid while grant_valid=1
//   grant_valid   high while in SERVICE
//   req_pending   qualified requests (status)
// -----------------------------------------------------------------------------
module dma_priority_resolver
    import dma_priority_resolver_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] dreq,
    input  logic       dreq_sense,
    input  logic       dack_sense,
    input  logic       rot_pri,
    input  logic       ctrl_disable,
    input  logic [3:0] mask,
    input  logic [3:0] sw_req,
    input  logic       hlda,
    input  logic       svc_done,
    output logic       hrq,
    output logic [3:0] dack,
    output logic [1:0] ch_sel,
    output logic       grant_valid,
    output logic [3:0] req_pending
);

    // The channel width is fixed at 2 bits throughout, so only 4 channels
    // make sense.
    if (NUM_CH != dma_priority_resolver_pkg::NUM_CH) begin : g_bad_num_ch
        $error("dma_priority_resolver supports exactly 4 channels");
    end
    if (SYNC_STAGES < 1) begin : g_bad_sync
        $error("SYNC_STAGES must be at least 1");
    end

    res_state_e      r_state;
    res_state_e      w_state_nxt;
    logic            r_hrq;
    logic            w_hrq_nxt;
    logic            r_grant_valid;
    logic            w_grant_valid_nxt;
    CHANNEL_SELECT_e r_ch_sel;
    CHANNEL_SELECT_e w_ch_sel_nxt;
    ch_idx_t         r_pri_ptr;
    ch_idx_t         w_pri_ptr_nxt;
    logic [3:0]      r_dack_q;
    logic [3:0]      w_dack_q_nxt;

    logic [3:0]      w_dreq_in;
    logic [3:0]      w_req_eff;
    logic [1:0]      w_winner;
    logic            w_any;

    // ------------------------------------------------------------------
    // DREQ input path
    // ------------------------------------------------------------------
`ifdef DMA_DREQ_SYNC_EN
    logic [3:0] r_dreq_sync [SYNC_STAGES];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                r_dreq_sync[s] <= 4'b0000;
            end
        end else begin
            r_dreq_sync[0] <= dreq;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                r_dreq_sync[s] <= r_dreq_sync[s-1];
            end
        end
    end

    assign w_dreq_in = r_dreq_sync[SYNC_STAGES-1];
`else
    assign w_dreq_in = dreq;
`endif

    assign w_req_eff = {4{~ctrl_disable}}
                     & (((w_dreq_in ^ {4{dreq_sense}}) & ~mask) | sw_req);

    dma_priority_encoder u_encoder (
        .req     (w_req_eff),
        .pri_ptr (r_pri_ptr),
        .winner  (w_winner),
        .any     (w_any)
    );

    // ------------------------------------------------------------------
    // Resolver FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_hrq         <= 1'b0;
            r_grant_valid <= 1'b0;
            r_ch_sel      <= CH_SEL_0;
            r_pri_ptr     <= 2'd0;
            r_dack_q      <= 4'b0000;
        end else begin
            r_state       <= w_state_nxt;
            r_hrq         <= w_hrq_nxt;
            r_grant_valid <= w_grant_valid_nxt;
            r_ch_sel      <= w_ch_sel_nxt;
            r_pri_ptr     <= w_pri_ptr_nxt;
            r_dack_q      <= w_dack_q_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_hrq_nxt         = r_hrq;
        w_grant_valid_nxt = r_grant_valid;
        w_ch_sel_nxt      = r_ch_sel;
        w_pri_ptr_nxt     = r_pri_ptr;
        w_dack_q_nxt      = r_dack_q;

        case (r_state)
            ST_IDLE: begin
                w_hrq_nxt         = 1'b0;
                w_grant_valid_nxt = 1'b0;
                w_dack_q_nxt      = 4'b0000;
                if (w_any) begin
                    w_state_nxt = ST_HOLD_REQ;
                    w_hrq_nxt   = 1'b1;
                end
            end

            ST_HOLD_REQ: begin
                w_hrq_nxt = 1'b1;
                if (hlda) begin
                    if (w_any) begin
                        w_state_nxt       = ST_SERVICE;
                        w_ch_sel_nxt      = CHANNEL_SELECT_e'(w_winner);
                        w_dack_q_nxt      = ch_onehot(w_winner);
                        w_grant_valid_nxt = 1'b1;
                    end else begin
                        // The request was withdrawn before the bus was granted.
                        // Hand the bus straight back to the CPU.
                        w_state_nxt = ST_RELEASE;
                        w_hrq_nxt   = 1'b0;
                    end
                end
            end

            ST_SERVICE: begin
                // svc_done has priority over a simultaneous hlda drop, so the
                // rotation still takes effect in that case.
                if (svc_done) begin
                    w_state_nxt       = ST_RELEASE;
                    w_hrq_nxt         = 1'b0;
                    w_grant_valid_nxt = 1'b0;
                    w_dack_q_nxt      = 4'b0000;
                    if (rot_pri) begin
                        w_pri_ptr_nxt = r_ch_sel + 2'd1;
                    end
                end else if (!hlda) begin
                    w_state_nxt       = ST_RELEASE;
                    w_hrq_nxt         = 1'b0;
                    w_grant_valid_nxt = 1'b0;
                    w_dack_q_nxt      = 4'b0000;
                end
            end

            ST_RELEASE: begin
                w_state_nxt       = ST_IDLE;
                w_hrq_nxt         = 1'b0;
                w_grant_valid_nxt = 1'b0;
                w_dack_q_nxt      = 4'b0000;
            end

            default: begin
                w_state_nxt       = ST_IDLE;
                w_hrq_nxt         = 1'b0;
                w_grant_valid_nxt = 1'b0;
                w_dack_q_nxt      = 4'b0000;
            end
        endcase

        // In fixed-priority mode channel 0 is always highest.
        if (!rot_pri) begin
            w_pri_ptr_nxt = 2'd0;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign hrq         = r_hrq;
    assign grant_valid = r_grant_valid;
    assign ch_sel      = r_ch_sel;
    assign dack        = dack_sense ? r_dack_q : ~r_dack_q;
    assign req_pending = w_req_eff;

endmodule

// File: tb/tb_dma_priority_resolver.sv
module tb_dma_priority_resolver;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] dreq;
    logic       dreq_sense;
    logic       dack_sense;
    logic       rot_pri;
    logic       ctrl_disable;
    logic [3:0] mask;
    logic [3:0] sw_req;
    logic       hlda;
    logic       svc_done;
    logic       hrq;
    logic [3:0] dack;
    logic [1:0] ch_sel;
    logic       grant_valid;
    logic [3:0] req_pending;

`ifdef DMA_DREQ_SYNC_EN
    localparam int DREQ_LAT = 3;
`else
    localparam int DREQ_LAT = 1;
`endif

    int n_checks = 0;
    int n_errors = 0;

    dma_priority_resolver dut (
        .clk          (clk),
        .reset        (reset),
        .dreq         (dreq),
        .dreq_sense   (dreq_sense),
        .dack_sense   (dack_sense),
        .rot_pri      (rot_pri),
        .ctrl_disable (ctrl_disable),
        .mask         (mask),
        .sw_req       (sw_req),
        .hlda         (hlda),
        .svc_done     (svc_done),
        .hrq          (hrq),
        .dack         (dack),
        .ch_sel       (ch_sel),
        .grant_valid  (grant_valid),
        .req_pending  (req_pending)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Inputs are driven, and outputs sampled, on the falling edge.
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [3:0] exp_dack(input int ch, input logic aks);
        logic [3:0] oh;
        oh = 4'(1 << ch);
        return aks ? oh : ~oh;
    endfunction

    // Reference: qualified requests and the winner, computed from the rules.
    function automatic logic [3:0] model_eff(input logic [3:0] d, input logic ds, input logic [3:0] m,
                                             input logic [3:0] sw, input logic dis);
        logic [3:0] e;
        for (int i = 0; i < 4; i++) begin
            e[i] = !dis && ((((d[i] != ds)) && !m[i]) || sw[i]);
        end
        return e;
    endfunction

    function automatic int model_winner(input logic [3:0] eff, input int ptr);
        for (int k = 0; k < 4; k++) begin
            if (eff[(ptr + k) % 4]) return (ptr + k) % 4;
        end
        return -1;
    endfunction

    task automatic apply_reset();
        reset = 1'b1;
        dreq = 4'b0000; dreq_sense = 1'b0; dack_sense = 1'b0; rot_pri = 1'b0;
        ctrl_disable = 1'b0; mask = 4'b0000; sw_req = 4'b0000; hlda = 1'b0; svc_done = 1'b0;
        step(2);
        reset = 1'b0;
    endtask

    task automatic wait_hrq(input string name);
        int n = 0;
        while (hrq !== 1'b1 && n < 20) begin
            step(1);
            n++;
        end
        check(name, hrq, 1);
    endtask

    task automatic take_grant(input string name, input int delay, input int exp_ch, input logic [3:0] exp_dk);
        step(delay);
        hlda = 1'b1;
        step(1);
        check({name, "_gv"}, grant_valid, 1);
        check({name, "_ch"}, ch_sel, exp_ch);
        check({name, "_dack"}, dack, exp_dk);
    endtask

    task automatic end_service(input string name, input bit use_done);
        if (use_done) svc_done = 1'b1;
        else hlda = 1'b0;
        step(1);
        svc_done = 1'b0;
        check({name, "_rel_gv"}, grant_valid, 0);
        check({name, "_rel_hrq"}, hrq, 0);
        check({name, "_rel_dack"}, dack, {4{~dack_sense}});
        hlda = 1'b0;
        step(1);
    endtask

    typedef struct {
        logic [3:0] dreq;
        logic       ds;
        logic       aks;
        logic [3:0] mask;
        logic [3:0] sw;
        int         exp_ch;
        logic [3:0] exp_dk;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int low;
        int m_ptr;
        logic [3:0] eff;
        int exp_ch;
        bit ok;

        vecs[0] = '{4'b1010, 1'b0, 1'b0, 4'b0000, 4'b0000, 1, 4'b1101};
        vecs[1] = '{4'b1110, 1'b1, 1'b1, 4'b0000, 4'b0000, 0, 4'b0001};
        vecs[2] = '{4'b1111, 1'b0, 1'b0, 4'b1111, 4'b0100, 2, 4'b1011};
        vecs[3] = '{4'b1000, 1'b0, 1'b1, 4'b0000, 4'b0000, 3, 4'b1000};
        vecs[4] = '{4'b1100, 1'b0, 1'b0, 4'b0100, 4'b0000, 3, 4'b0111};
        vecs[5] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 4'b1010, 1, 4'b1101};
        vecs[6] = '{4'b0101, 1'b1, 1'b0, 4'b0010, 4'b0000, 3, 4'b0111};

        // Reset state
        apply_reset();
        check("rst_hrq", hrq, 0);
        check("rst_gv", grant_valid, 0);
        check("rst_ch", ch_sel, 0);
        check("rst_dack", dack, 4'b1111);

        // Table: single grants from reset (pointer 0)
        for (int v = 0; v < 7; v++) begin
            apply_reset();
            dreq = vecs[v].dreq; dreq_sense = vecs[v].ds; dack_sense = vecs[v].aks;
            mask = vecs[v].mask; sw_req = vecs[v].sw;
            step(DREQ_LAT);
            check($sformatf("vec%0d_hrq", v), hrq, 1);
            take_grant($sformatf("vec%0d", v), 3, vecs[v].exp_ch, vecs[v].exp_dk);
            end_service($sformatf("vec%0d", v), 1'b1);
        end

        // Fixed priority: ch1 then ch3, with hrq low between grants
        apply_reset();
        dreq = 4'b1010;
        step(DREQ_LAT);
        take_grant("fix1", 3, 1, 4'b1101);
        svc_done = 1'b1;
        step(1);
        svc_done = 1'b0;
        dreq = 4'b1000;
        hlda = 1'b0;
        check("fix_gap_hrq", hrq, 0);
        low = 1;
        while (hrq !== 1'b1 && low < 20) begin
            step(1);
            if (hrq !== 1'b1) low++;
        end
        check("fix_gap_ok", (hrq === 1'b1 && low >= 1), 1);
        take_grant("fix2", 1, 3, 4'b0111);
        end_service("fix2", 1'b1);

        // Rotating priority: 0,1,2,3,0
        apply_reset();
        rot_pri = 1'b1;
        dreq = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_hrq($sformatf("rot%0d_hrq", i));
            take_grant($sformatf("rot%0d", i), 0, i % 4, exp_dack(i % 4, 1'b0));
            end_service($sformatf("rot%0d", i), 1'b1);
        end

        // Mask blocks hardware, software request gets through
        apply_reset();
        mask = 4'b1111;
        dreq = 4'b1111;
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1);
            if (hrq !== 1'b0) ok = 1'b0;
        end
        check("mask_hrq_low", ok, 1);
        check("mask_pending", req_pending, 4'b0000);
        sw_req = 4'b0100;
        step(1);
        check("sw_hrq", hrq, 1);
        take_grant("sw", 2, 2, 4'b1011);
        end_service("sw", 1'b1);

        // Withdraw before hlda; svc_done outside SERVICE is ignored
        apply_reset();
        dreq = 4'b0001;
        step(DREQ_LAT);
        svc_done = 1'b1;
        step(1);
        svc_done = 1'b0;
        check("stray_done_hrq", hrq, 1);
        dreq = 4'b0000;
        hlda = 1'b1;
        step(1);
        check("wd_hrq", hrq, 0);
        check("wd_gv", grant_valid, 0);
        check("wd_dack", dack, 4'b1111);
        hlda = 1'b0;
        step(1);

        // Abort keeps the pointer; svc_done plus hlda drop still rotates
        apply_reset();
        rot_pri = 1'b1;
        dreq = 4'b1111;
        wait_hrq("ab0_hrq");
        take_grant("ab0", 0, 0, 4'b1110);
        end_service("ab0", 1'b1);
        wait_hrq("ab1_hrq");
        take_grant("ab1", 1, 1, 4'b1101);
        end_service("ab1", 1'b0);
        wait_hrq("ab2_hrq");
        take_grant("ab2", 2, 1, 4'b1101);
        svc_done = 1'b1;
        hlda = 1'b0;
        step(1);
        svc_done = 1'b0;
        check("both_gv", grant_valid, 0);
        step(1);
        wait_hrq("ab3_hrq");
        take_grant("ab3", 0, 2, 4'b1011);
        end_service("ab3", 1'b1);

        // Asynchronous reset in SERVICE on ch2
        apply_reset();
        rot_pri = 1'b1;
        dreq = 4'b0010;
        wait_hrq("rs0_hrq");
        take_grant("rs0", 0, 1, 4'b1101);
        end_service("rs0", 1'b1);
        dreq = 4'b1111;
        wait_hrq("rs1_hrq");
        take_grant("rs1", 0, 2, 4'b1011);
        #2 reset = 1'b1;
        #1;
        check("arst_hrq", hrq, 0);
        check("arst_gv", grant_valid, 0);
        check("arst_dack", dack, 4'b1111);
        hlda = 1'b0;
        step(1);
        reset = 1'b0;
        wait_hrq("rs2_hrq");
        take_grant("rs2", 0, 0, 4'b1110);
        end_service("rs2", 1'b1);

        // Randomized transactions against the reference model
        apply_reset();
        m_ptr = 0;
        for (int t = 0; t < 80; t++) begin
            bit use_done;
            dreq = 4'($urandom);
            mask = 4'($urandom);
            sw_req = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
            dreq_sense = 1'($urandom);
            dack_sense = 1'($urandom);
            rot_pri = 1'($urandom);
            ctrl_disable = ($urandom_range(0, 7) == 0);
            eff = model_eff(dreq, dreq_sense, mask, sw_req, ctrl_disable);
            if (!rot_pri) m_ptr = 0;
            step(1);
            check($sformatf("rnd%0d_pending", t), req_pending, eff);
            if (eff == 4'b0000) begin
                check($sformatf("rnd%0d_idle_hrq", t), hrq, 0);
                continue;
            end
            check($sformatf("rnd%0d_hrq", t), hrq, 1);
            exp_ch = model_winner(eff, m_ptr);
            take_grant($sformatf("rnd%0d", t), $urandom_range(0, 3), exp_ch, exp_dack(exp_ch, dack_sense));
            for (int h = $urandom_range(0, 3); h > 0; h--) begin
                dreq = 4'($urandom);
                mask = 4'($urandom);
                ctrl_disable = 1'($urandom);
                step(1);
            end
            check($sformatf("rnd%0d_hold_gv", t), grant_valid, 1);
            check($sformatf("rnd%0d_hold_ch", t), ch_sel, exp_ch);
            use_done = ($urandom_range(0, 3) != 0);
            end_service($sformatf("rnd%0d", t), use_done);
            if (use_done && rot_pri) m_ptr = (exp_ch + 1) % 4;
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
